// File: rtl/radix4_seq_divider.sv
// Sequential radix-4 restoring divider: two quotient bits per cycle against 1x/2x/3x divisor multiples.
// Unsigned or two's-complement operands (sign_op); results and div_by_zero hold until the next done pulse.
module radix4_seq_divider #(
  parameter int num_bits = 32,
  parameter bit sign_op  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [num_bits-1:0] dividend,
  input  logic [num_bits-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [num_bits-1:0] quotient,
  output logic [num_bits-1:0] remainder,
  output logic                div_by_zero
);
  localparam int W    = num_bits + 2;
  localparam int NDIG = num_bits / 2;
  localparam int CW   = $clog2(NDIG) + 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, RES} state_t;
  state_t state_q, state_d;

  logic [num_bits-1:0] dvd_q, dvd_d, qacc_q, qacc_d, quo_q, quo_d, rem_q, rem_d;
  logic [W-1:0]        d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, r_q, r_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
  logic                done_q, done_d, dbz_q, dbz_d;

  logic                dvd_neg, dsr_neg;
  logic [num_bits-1:0] dvd_mag, dsr_mag, rem_mag;
  logic [W-1:0]        t, sub;
  logic [1:0]          digit;

  always_comb begin
    dvd_neg = sign_op && dividend[num_bits-1];
    dsr_neg = sign_op && divisor[num_bits-1];
    dvd_mag = dvd_neg ? -dividend : dividend;
    dsr_mag = dsr_neg ? -divisor : divisor;
    rem_mag = r_q[num_bits-1:0];
    // Partial remainder shifted up by one digit, next two dividend bits brought in.
    t = (r_q << 2) | W'(dvd_q[num_bits-1 -: 2]);
    if (t >= d3_q) begin
      digit = 2'd3;
      sub   = d3_q;
    end else if (t >= d2_q) begin
      digit = 2'd2;
      sub   = d2_q;
    end else if (t >= d1_q) begin
      digit = 2'd1;
      sub   = d1_q;
    end else begin
      digit = 2'd0;
      sub   = '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = LOAD;
      LOAD:    state_d = (divisor == '0) ? RES : DIV;
      DIV:     if (cnt_q == LAST) state_d = RES;
      RES:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state_q != IDLE);
    done        = done_q;
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

  always_comb begin
    dvd_d  = dvd_q;
    qacc_d = qacc_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    d1_d   = d1_q;
    d2_d   = d2_q;
    d3_d   = d3_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    zero_d = zero_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
    case (state_q)
      LOAD: begin
        zero_d = (divisor == '0);
        // A zero divisor keeps the raw dividend so it can be returned as the remainder.
        dvd_d  = (divisor == '0) ? dividend : dvd_mag;
        d1_d   = W'(dsr_mag);
        d2_d   = W'(dsr_mag) << 1;
        d3_d   = W'(dsr_mag) + (W'(dsr_mag) << 1);
        qneg_d = dvd_neg ^ dsr_neg;
        rneg_d = dvd_neg;
        r_d    = '0;
        qacc_d = '0;
        cnt_d  = '0;
      end
      DIV: begin
        r_d    = t - sub;
        qacc_d = {qacc_q[num_bits-3:0], digit};
        dvd_d  = dvd_q << 2;
        cnt_d  = cnt_q + 1'b1;
      end
      RES: begin
        done_d = 1'b1;
        dbz_d  = zero_q;
        if (zero_q) begin
          quo_d = '1;
          rem_d = dvd_q;
        end else begin
          quo_d = qneg_q ? -qacc_q : qacc_q;
          rem_d = rneg_q ? -rem_mag : rem_mag;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      qacc_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
      d3_q   <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      qacc_q <= qacc_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      d3_q   <= d3_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      zero_q <= zero_d;
      dbz_q  <= dbz_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_radix4_seq_divider.sv
// Scoreboard bench: 32-bit unsigned (inst 0), 32-bit signed (inst 1) and 8-bit unsigned (inst 2) dividers.
module tb_radix4_seq_divider;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  rst, load;
  logic [31:0] a[2], b[2];
  logic [7:0]  a8, b8;
  wire  [2:0]  busy_w, done_w, z_w;
  wire  [31:0] q_w[3], r_w[3];
  wire  [7:0]  q8, r8;
  assign q_w[2] = {24'd0, q8};
  assign r_w[2] = {24'd0, r8};

  radix4_seq_divider #(.num_bits(32), .sign_op(1'b0)) u_du (
    .clk(clk), .rst(rst[0]), .load(load[0]), .dividend(a[0]), .divisor(b[0]),
    .busy(busy_w[0]), .done(done_w[0]), .quotient(q_w[0]), .remainder(r_w[0]), .div_by_zero(z_w[0]));
  radix4_seq_divider #(.num_bits(32), .sign_op(1'b1)) u_ds (
    .clk(clk), .rst(rst[1]), .load(load[1]), .dividend(a[1]), .divisor(b[1]),
    .busy(busy_w[1]), .done(done_w[1]), .quotient(q_w[1]), .remainder(r_w[1]), .div_by_zero(z_w[1]));
  radix4_seq_divider #(.num_bits(8), .sign_op(1'b0)) u_d8 (
    .clk(clk), .rst(rst[2]), .load(load[2]), .dividend(a8), .divisor(b8),
    .busy(busy_w[2]), .done(done_w[2]), .quotient(q8), .remainder(r8), .div_by_zero(z_w[2]));

  typedef struct {
    int          inst;
    logic [31:0] a, b, q, r;
    logic        z;
    int          k;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", nm, inst, act, expv);
    end
  endtask

  function automatic int nbits(input int i);
    return (i == 2) ? 8 : 32;
  endfunction

  function automatic longint msk(input int i);
    return (64'sd1 <<< nbits(i)) - 64'sd1;
  endfunction

  function automatic longint sext(input int i, input logic [31:0] v);
    longint x, h;
    x = longint'(v) & msk(i);
    h = 64'sd1 <<< (nbits(i) - 1);
    return (x ^ h) - h;
  endfunction

  // Reference: plain integer division on 64-bit values, truncating toward zero.
  function automatic exp_t model(input int i, input logic [31:0] av, input logic [31:0] bv, input int k);
    exp_t   e;
    longint ua, ub, sa, sb;
    ua = longint'(av) & msk(i);
    ub = longint'(bv) & msk(i);
    e.inst = i; e.a = av; e.b = bv; e.k = k;
    if (ub == 0) begin
      e.q = 32'(msk(i)); e.r = 32'(ua); e.z = 1'b1; e.lat = 2;
    end else begin
      e.z = 1'b0; e.lat = nbits(i) / 2 + 2;
      if (i == 1) begin
        sa = sext(i, av); sb = sext(i, bv);
        e.q = 32'((sa / sb) & msk(i));
        e.r = 32'((sa % sb) & msk(i));
      end else begin
        e.q = 32'(ua / ub);
        e.r = 32'(ua % ub);
      end
    end
    return e;
  endfunction

  // Algebraic check: a == q*b + r, |r| < |b|, remainder takes the dividend's sign.
  function automatic bit rules_ok(input int i, input logic [31:0] av, input logic [31:0] bv,
                                  input logic [31:0] qv, input logic [31:0] rv);
    longint sa, sb, sq, sr, ua, ub, uq, ur;
    if (i == 1) begin
      sa = sext(i, av); sb = sext(i, bv); sq = sext(i, qv); sr = sext(i, rv);
      return (((sq * sb + sr) & msk(i)) == (sa & msk(i))) &&
             ((sr < 0 ? -sr : sr) < (sb < 0 ? -sb : sb)) &&
             (sr == 0 || ((sr < 0) == (sa < 0)));
    end
    ua = longint'(av) & msk(i); ub = longint'(bv) & msk(i);
    uq = longint'(qv) & msk(i); ur = longint'(rv) & msk(i);
    return (((uq * ub + ur) & msk(i)) == ua) && (ur < ub);
  endfunction

  // Monitor: pops the oldest expectation for whichever instance reports done.
  always @(negedge clk) begin
    int   idx;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (done_w[i]) begin
        idx = -1;
        for (int j = 0; j < sbq.size(); j++) begin
          if (sbq[j].inst == i) begin
            idx = j;
            break;
          end
        end
        if (idx < 0) begin
          chk("unexpected_done", i, 64'd1, 64'd0);
        end else begin
          e = sbq[idx];
          sbq.delete(idx);
          chk("quotient", i, q_w[i], e.q);
          chk("remainder", i, r_w[i], e.r);
          chk("div_by_zero", i, z_w[i], e.z);
          chk("latency", i, cyc - e.k, e.lat);
          if (!e.z) chk("div_rules", i, rules_ok(i, e.a, e.b, q_w[i], r_w[i]), 1);
        end
      end
    end
  end

  task automatic drive(input int i, input logic [31:0] av, input logic [31:0] bv);
    if (i == 2) begin
      a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      a[i] = av; b[i] = bv;
    end
  endtask

  task automatic start(input int i, input logic [31:0] av, input logic [31:0] bv, input bit track);
    drive(i, av, bv);
    load[i] = 1'b1;
    if (track) sbq.push_back(model(i, av, bv, cyc + 1));
  endtask

  task automatic run_op(input int i, input logic [31:0] av, input logic [31:0] bv);
    int nb;
    start(i, av, bv, 1'b1);
    nb = 0;
    @(negedge clk);
    load[i] = 1'b0;
    while (busy_w[i] && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    if (nb >= 100) chk("timeout", i, 64'd1, 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(1, 15));
      5:       return 32'h0000_0080;
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog inst-1: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb, k0, guard;
    rst = 3'b111; load = 3'b000;
    a[0] = 0; b[0] = 0; a[1] = 0; b[1] = 0; a8 = 0; b8 = 0;
    repeat (3) @(negedge clk);
    rst = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chk("reset_flags", i, {busy_w[i], done_w[i], z_w[i]}, 3'b000);
      chk("reset_data", i, {q_w[i], r_w[i]}, 64'd0);
    end

    // Directed unsigned
    run_op(0, 100, 7);
    run_op(0, 32'hFFFF_FFFF, 1);
    run_op(0, 5, 9);
    run_op(0, 1234, 0);
    run_op(0, 100, 7);
    // Directed signed
    run_op(1, -7, 2);
    run_op(1, 7, -2);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1, -5, 0);
    run_op(1, -100, -7);
    // Directed 8-bit
    run_op(2, 200, 3);
    run_op(2, 255, 0);

    // load pulse mid-operation must be ignored; busy held for the whole op
    start(0, 100, 7, 1'b1);
    nb = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      load[0] = (c == 4);
      if (c == 4) drive(0, 999, 3);
      if (!busy_w[0]) break;
      nb++;
    end
    load[0] = 1'b0;
    chk("busy_held", 0, nb, 18);
    repeat (25) @(negedge clk);

    // load held high restarts in the cycle after done
    start(0, 20, 3, 1'b1);
    k0 = cyc + 1;
    sbq.push_back(model(0, 20, 3, k0 + 19));
    while (cyc < k0 + 19) @(negedge clk);
    load[0] = 1'b0;
    guard = 0;
    while (busy_w[0] && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    chk("restart_idle", 0, busy_w[0], 1'b0);

    // Reset in the 8th DIV cycle aborts with no done
    start(0, 100, 7, 1'b0);
    @(negedge clk);
    load[0] = 1'b0;
    repeat (8) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("abort_flags", 0, {busy_w[0], done_w[0], z_w[0]}, 3'b000);
    chk("abort_data", 0, {q_w[0], r_w[0]}, 64'd0);
    repeat (20) @(negedge clk);
    run_op(0, 100, 7);

    // Randomized sweep, all three instances in lock step
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) start(i, rnd_val(), rnd_val(), 1'b1);
      @(negedge clk);
      load = 3'b000;
      guard = 0;
      while ((|busy_w) && guard < 100) begin
        guard++;
        @(negedge clk);
      end
      if (guard >= 100) chk("timeout_rand", -1, 64'd1, 64'd0);
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", -1, sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
